// File: rtl/vend_arb_pkg.sv
// Shared types and constants for the vending-core arbiter.
package vend_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        CLEAR = 2'd2
    } state_e;

    localparam int unsigned MAX_NREQ = 8;
    localparam int unsigned CNT_W    = 8;

    // Saturating increment for the idle-coin counter.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/vend_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted req after ptr, wrapping.
module rr_pick #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IW   = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic            valid,
    output logic [IW-1:0]   idx,
    output logic [NREQ-1:0] sel
);

    logic [IW-1:0] cand;

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        sel   = '0;
        cand  = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = IW'((32'(ptr) + k) % NREQ);
            if (!valid && req[cand]) begin
                valid     = 1'b1;
                idx       = cand;
                sel[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vend_arbiter.sv
// Round-robin arbiter sharing one Mealy vending core among NREQ requesters.
// Optional idle-coin timeout abort is enabled by defining VEND_ARB_TIMEOUT_EN.
module vend_arbiter
    import vend_arb_pkg::*;
#(
    parameter int unsigned NREQ    = 2,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] coin_i,
    input  logic [NREQ-1:0] coin_j,
    output logic [NREQ-1:0] gnt,
    output logic [NREQ-1:0] done,
    output logic [NREQ-1:0] chg,
    output logic [NREQ-1:0] abort,
    output logic            vend_i,
    output logic            vend_j,
    input  logic            vend_x,
    input  logic            vend_y,
    output logic            vend_rst
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    if (NREQ < 2 || NREQ > MAX_NREQ || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_cfg
        $error("vend_arbiter: parameter out of range");
    end

    state_e          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] done_q, done_d;
    logic [NREQ-1:0] chg_q, chg_d;
    logic [NREQ-1:0] abort_q, abort_d;

    logic            pick_valid;
    logic [IW-1:0]   pick_idx;
    logic [NREQ-1:0] pick_sel;
    logic            serving;
    logic            tmo_hit;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx),
        .sel   (pick_sel)
    );

`ifdef VEND_ARB_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             own_coin;

    assign own_coin = coin_i[owner_q] | coin_j[owner_q];
    // Fires on the TIMEOUT-th consecutive coinless SERVE cycle.
    assign tmo_hit  = !own_coin && (cnt_q >= CNT_W'(TIMEOUT - 1));
`else
    assign tmo_hit  = 1'b0;
`endif

    assign serving  = (state_q == SERVE) && !rst;
    assign vend_i   = serving & coin_i[owner_q];
    assign vend_j   = serving & coin_j[owner_q];
    assign vend_rst = rst | ((state_q == CLEAR) && (|abort_q));

    assign gnt   = gnt_q;
    assign done  = done_q;
    assign chg   = chg_q;
    assign abort = abort_q;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        chg_d   = '0;
        abort_d = '0;
`ifdef VEND_ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    owner_d = pick_idx;
                    gnt_d   = pick_sel;
                    state_d = SERVE;
`ifdef VEND_ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            SERVE: begin
`ifdef VEND_ARB_TIMEOUT_EN
                cnt_d = own_coin ? '0 : sat_inc(cnt_q);
`endif
                // Dispense outranks withdrawal, which outranks timeout.
                if (vend_x) begin
                    done_d[owner_q] = 1'b1;
                    chg_d[owner_q]  = vend_y;
                    gnt_d           = '0;
                    state_d         = CLEAR;
                end else if (!req[owner_q] || tmo_hit) begin
                    abort_d[owner_q] = 1'b1;
                    gnt_d            = '0;
                    state_d          = CLEAR;
                end
            end
            CLEAR: begin
                ptr_d   = owner_q;
                state_d = IDLE;
            end
            default: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= IW'(NREQ - 1);
            owner_q <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            chg_q   <= '0;
            abort_q <= '0;
`ifdef VEND_ARB_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            chg_q   <= chg_d;
            abort_q <= abort_d;
`ifdef VEND_ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_vend_arbiter.sv
// Self-checking bench for vend_arbiter: vector table, corner sequences, random vs. model.
module tb_vend_arbiter;

    localparam int unsigned NREQ = 2;
    localparam int unsigned TMO  = 15;

    logic            clk = 1'b0;
    logic            rst;
    logic [NREQ-1:0] req, coin_i, coin_j;
    logic [NREQ-1:0] gnt, done, chg, abort;
    logic            vend_i, vend_j, vend_x, vend_y, vend_rst;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    vend_arbiter #(
        .NREQ    (NREQ),
        .TIMEOUT (TMO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .coin_i   (coin_i),
        .coin_j   (coin_j),
        .gnt      (gnt),
        .done     (done),
        .chg      (chg),
        .abort    (abort),
        .vend_i   (vend_i),
        .vend_j   (vend_j),
        .vend_x   (vend_x),
        .vend_y   (vend_y),
        .vend_rst (vend_rst)
    );

    typedef struct {
        logic       rst;
        logic [1:0] req, ci, cj;
        logic       x, y;
        logic [1:0] gnt, done, chg, abort;
        logic       vi, vj, vr;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [10:0] outs();
        return {gnt, done, chg, abort, vend_i, vend_j, vend_rst};
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; coin_i = '0; coin_j = '0; vend_x = 1'b0; vend_y = 1'b0;
        next_cycle();
        rst = 1'b0;
    endtask

    function automatic vec_t mk(input logic r, input logic [1:0] rq, input logic [1:0] ci,
                                input logic [1:0] cj, input logic x, input logic y,
                                input logic [1:0] g, input logic [1:0] d, input logic [1:0] c,
                                input logic [1:0] a, input logic vi, input logic vj, input logic vr);
        vec_t v;
        v.rst = r; v.req = rq; v.ci = ci; v.cj = cj; v.x = x; v.y = y;
        v.gnt = g; v.done = d; v.chg = c; v.abort = a; v.vi = vi; v.vj = vj; v.vr = vr;
        return v;
    endfunction

    // Reference model state: session owner (-1 none), pending wrap-up result.
    int m_owner, m_kind, m_res_owner, m_last, m_quiet;
    bit m_res_chg;

    task automatic model_reset();
        m_owner = -1; m_kind = 0; m_res_owner = 0; m_last = NREQ - 1; m_quiet = 0; m_res_chg = 0;
    endtask

    task automatic model_step(input logic r, input logic [1:0] rq, input logic [1:0] ci,
                              input logic [1:0] cj, input logic x, input logic y,
                              output logic [10:0] exp);
        logic [1:0] eg, ed, ec, ea;
        logic       evi, evj, evr;
        int         c;
        eg  = (m_owner >= 0) ? 2'(1 << m_owner) : 2'b00;
        ed  = (m_kind == 1) ? 2'(1 << m_res_owner) : 2'b00;
        ec  = (m_kind == 1 && m_res_chg) ? 2'(1 << m_res_owner) : 2'b00;
        ea  = (m_kind == 2) ? 2'(1 << m_res_owner) : 2'b00;
        evi = (!r && m_owner >= 0) ? ci[m_owner] : 1'b0;
        evj = (!r && m_owner >= 0) ? cj[m_owner] : 1'b0;
        evr = r || (m_kind == 2);
        exp = {eg, ed, ec, ea, evi, evj, evr};
        if (r) begin
            model_reset();
        end else if (m_kind != 0) begin
            m_last = m_res_owner;
            m_kind = 0;
        end else if (m_owner >= 0) begin
            m_quiet = (ci[m_owner] || cj[m_owner]) ? 0 : m_quiet + 1;
            if (x) begin
                m_kind = 1; m_res_chg = y; m_res_owner = m_owner; m_owner = -1;
            end else if (!rq[m_owner]) begin
                m_kind = 2; m_res_owner = m_owner; m_owner = -1;
            end
`ifdef VEND_ARB_TIMEOUT_EN
            else if (m_quiet >= int'(TMO)) begin
                m_kind = 2; m_res_owner = m_owner; m_owner = -1;
            end
`endif
        end else begin
            for (int k = 1; k <= int'(NREQ); k++) begin
                c = (m_last + k) % int'(NREQ);
                if (m_owner < 0 && rq[c]) begin
                    m_owner = c;
                    m_quiet = 0;
                end
            end
        end
    endtask

    vec_t tbl[16];

    initial begin
        logic [10:0] exp;
        int          starts[$];
        logic [1:0]  gvals[$];
        int          in_sess;
        int          ab_cyc;
        logic        ab_rst;
        logic        ab_after;

        rst = 1'b1; req = '0; coin_i = '0; coin_j = '0; vend_x = 1'b0; vend_y = 1'b0;
        next_cycle();
        next_cycle();

        //             rst req   ci     cj     x  y  gnt    done   chg    abort  vi vj vr
        tbl[0]  = mk(1, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 1);
        tbl[1]  = mk(0, 2'b01, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0);
        tbl[2]  = mk(0, 2'b01, 2'b01, 2'b00, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 1, 0, 0);
        tbl[3]  = mk(0, 2'b01, 2'b00, 2'b01, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 0, 1, 0);
        tbl[4]  = mk(0, 2'b01, 2'b01, 2'b00, 1, 0, 2'b01, 2'b00, 2'b00, 2'b00, 1, 0, 0);
        tbl[5]  = mk(0, 2'b01, 2'b00, 2'b00, 1, 1, 2'b00, 2'b01, 2'b00, 2'b00, 0, 0, 0);
        tbl[6]  = mk(0, 2'b01, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0);
        tbl[7]  = mk(0, 2'b11, 2'b00, 2'b00, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 0, 0, 0);
        tbl[8]  = mk(0, 2'b10, 2'b10, 2'b10, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 0, 0, 0);
        tbl[9]  = mk(0, 2'b10, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 2'b01, 0, 0, 1);
        tbl[10] = mk(0, 2'b10, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0);
        tbl[11] = mk(0, 2'b10, 2'b10, 2'b00, 0, 0, 2'b10, 2'b00, 2'b00, 2'b00, 1, 0, 0);
        tbl[12] = mk(0, 2'b00, 2'b00, 2'b00, 1, 1, 2'b10, 2'b00, 2'b00, 2'b00, 0, 0, 0);
        tbl[13] = mk(0, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 2'b10, 2'b10, 2'b00, 0, 0, 0);
        tbl[14] = mk(0, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0);
        tbl[15] = mk(0, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0);

        for (int i = 0; i < 16; i++) begin
            rst = tbl[i].rst; req = tbl[i].req; coin_i = tbl[i].ci; coin_j = tbl[i].cj;
            vend_x = tbl[i].x; vend_y = tbl[i].y;
            @(negedge clk);
            check($sformatf("vec[%0d] {gnt,done,chg,abort,vi,vj,vrst}", i), 32'(outs()),
                  32'({tbl[i].gnt, tbl[i].done, tbl[i].chg, tbl[i].abort,
                       tbl[i].vi, tbl[i].vj, tbl[i].vr}));
            next_cycle();
        end

        // Three back-to-back sessions with both requesters holding req.
        do_reset();
        req = 2'b11;
        in_sess = 0;
        for (int cyc = 0; cyc < 40 && starts.size() < 3; cyc++) begin
            if (gnt != 2'b00) begin
                in_sess++;
                if (in_sess == 1) begin
                    starts.push_back(cyc);
                    gvals.push_back(gnt);
                end
                vend_x = (in_sess == 2);
            end else begin
                in_sess = 0;
                vend_x  = 1'b0;
            end
            next_cycle();
        end
        vend_x = 1'b0; req = 2'b00;
        check("rr_session_count", 32'(starts.size()), 32'd3);
        if (starts.size() == 3) begin
            check("rr_gnt0", 32'(gvals[0]), 32'b01);
            check("rr_gnt1", 32'(gvals[1]), 32'b10);
            check("rr_gnt2", 32'(gvals[2]), 32'b01);
            check("rr_spacing01", 32'(starts[1] - starts[0]), 32'd4);
            check("rr_spacing12", 32'(starts[2] - starts[1]), 32'd4);
        end

        // Reset landing in the middle of a session.
        do_reset();
        req = 2'b01;
        next_cycle();
        rst = 1'b1; coin_i = 2'b01; coin_j = 2'b01;
        @(negedge clk);
        check("rst_serve_vend_ij", 32'({vend_i, vend_j}), 32'b00);
        check("rst_serve_vend_rst", 32'(vend_rst), 32'd1);
        next_cycle();
        rst = 1'b0; req = 2'b11; coin_i = '0; coin_j = '0;
        @(negedge clk);
        check("post_rst_outs", 32'(outs()), 32'd0);
        next_cycle();
        @(negedge clk);
        check("post_rst_winner", 32'(gnt), 32'b01);
        next_cycle();

`ifdef VEND_ARB_TIMEOUT_EN
        // Coinless session: abort on the cycle after TMO idle SERVE cycles, optionally
        // restarted by a single coin on SERVE cycle 14.
        for (int sc = 0; sc < 2; sc++) begin
            do_reset();
            req = 2'b01;
            next_cycle();
            ab_cyc = 0; ab_rst = 1'b0; ab_after = 1'b0;
            for (int k = 1; k <= 40 && ab_cyc == 0; k++) begin
                coin_i = (sc == 1 && k == 14) ? 2'b01 : 2'b00;
                @(negedge clk);
                if (abort[0]) begin
                    ab_cyc = k;
                    ab_rst = vend_rst;
                end
                next_cycle();
            end
            coin_i = '0;
            @(negedge clk);
            ab_after = abort[0];
            check($sformatf("timeout_cycle[%0d]", sc), 32'(ab_cyc), (sc == 0) ? 32'd16 : 32'd30);
            check($sformatf("timeout_vend_rst[%0d]", sc), 32'(ab_rst), 32'd1);
            check($sformatf("timeout_single_pulse[%0d]", sc), 32'(ab_after), 32'd0);
            next_cycle();
        end
`else
        // Without the timeout feature a coinless session is never aborted.
        do_reset();
        req = 2'b01;
        next_cycle();
        ab_cyc = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (abort != 2'b00) ab_cyc++;
            next_cycle();
        end
        check("no_timeout_aborts", 32'(ab_cyc), 32'd0);
        @(negedge clk);
        check("no_timeout_gnt_held", 32'(gnt), 32'b01);
        next_cycle();
`endif

        // Randomized traffic against the reference model.
        do_reset();
        model_reset();
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(99) == 0);
            for (int b = 0; b < int'(NREQ); b++) begin
                if ($urandom_range(99) < 12) req[b] = ~req[b];
            end
            coin_i = 2'($urandom_range(3));
            coin_j = 2'($urandom_range(3));
            vend_x = ($urandom_range(99) < 15);
            vend_y = 1'($urandom_range(1));
            if ($urandom_range(3) == 0) begin
                coin_i = '0;
                coin_j = '0;
            end
            model_step(rst, req, coin_i, coin_j, vend_x, vend_y, exp);
            @(negedge clk);
            if (outs() !== exp) begin
                check($sformatf("rand[%0d] {gnt,done,chg,abort,vi,vj,vrst}", n),
                      32'(outs()), 32'(exp));
            end else begin
                checks++;
            end
            next_cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
